// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants, colour-mux select codes and the
// frame-phase FSM encoding shared by the VGA layer controller.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 525

  localparam int H_SYNC_START = H_ACTIVE + H_FP;              // 656
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;        // 752, exclusive
  localparam int V_SYNC_START = V_ACTIVE + V_FP;              // 490
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;        // 492, exclusive

  typedef enum logic [1:0] {
    SEL_FONDO  = 2'b00,  // background
    SEL_PRU    = 2'b01,  // test-pattern white
    SEL_LINEAS = 2'b10,  // grid lines
    SEL_SPRIT  = 2'b11   // sprite
  } sel_t;

  typedef enum logic {
    S_ACTIVE = 1'b0,
    S_VBLANK = 1'b1
  } state_t;

endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running horizontal/vertical pixel counters with the raw
// (undelayed) active-low syncs and the active-region flag for the same pixel.
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       active
);

  logic [9:0] h_nxt;
  logic [9:0] v_nxt;

  // Next counter values: h wraps at end of line and carries into v.
  always_comb begin
    h_nxt = h_cnt + 10'd1;
    v_nxt = v_cnt;
    if (h_cnt == 10'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (v_cnt == 10'(V_TOTAL - 1)) ? '0 : v_cnt + 10'd1;
    end
  end

  // Counter registers, both loaded every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
    end
  end

  assign hs_raw = ~((h_cnt >= 10'(H_SYNC_START)) && (h_cnt < 10'(H_SYNC_END)));
  assign vs_raw = ~((v_cnt >= 10'(V_SYNC_START)) && (v_cnt < 10'(V_SYNC_END)));
  assign active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

endmodule

// File: rtl/vga_layer_ctrl.sv
// vga_layer_ctrl: VGA 640x480 layer selector. Picks background, grid lines or
// a square sprite per pixel; sprite moves are accepted only in vertical blank
// and take effect at the next frame start.
// Optional build macro VGA_LAYER_TEST_PATTERN_EN adds input test_en, which
// replaces the layers with a 32-pixel checkerboard (select 01 / 00).
module vga_layer_ctrl
  import vga_pkg::*;
#(
  parameter int GRID_STEP = 64,  // power of 2
  parameter int LINE_T    = 2,   // < GRID_STEP
  parameter int SPRITE_SZ = 32
) (
  input  logic       clk,
  input  logic       rst,
`ifdef VGA_LAYER_TEST_PATTERN_EN
  input  logic       test_en,
`endif
  input  logic       upd_valid,
  input  logic [9:0] upd_x,
  input  logic [9:0] upd_y,
  output logic       upd_ready,
  output logic [1:0] selector,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  localparam logic [9:0]  X_MAX     = 10'(H_ACTIVE - SPRITE_SZ);
  localparam logic [9:0]  Y_MAX     = 10'(V_ACTIVE - SPRITE_SZ);
  localparam logic [9:0]  GRID_MASK = 10'(GRID_STEP - 1);
  localparam logic [9:0]  LINE_W    = 10'(LINE_T);
  localparam logic [10:0] SPR_W     = 11'(SPRITE_SZ);

  // Keep the whole sprite on screen.
  function automatic logic [9:0] sat_pos(input logic [9:0] p, input logic [9:0] lim);
    return (p > lim) ? lim : p;
  endfunction

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       active;

  vga_timing u_timing (
    .clk    (clk),
    .rst    (rst),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .hs_raw (hs_raw),
    .vs_raw (vs_raw),
    .active (active)
  );

  state_t     state;
  state_t     state_n;
  logic       line_end;
  logic       frame_go;
  logic       accept;
  logic [9:0] upd_x_sat;
  logic [9:0] upd_y_sat;
  logic [9:0] shx;
  logic [9:0] shy;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       in_sprite;
  logic       on_grid;
  sel_t       sel_p0;
  sel_t       sel_p1;
  logic       vid_p1;
  logic       fs_p1;
  logic       hs_p1;
  logic       hs_p2;
  logic       vs_p1;
  logic       vs_p2;

  assign line_end  = (h_cnt == 10'(H_TOTAL - 1));
  assign accept    = upd_valid && upd_ready;
  assign frame_go  = (state == S_VBLANK) && (state_n == S_ACTIVE);
  assign upd_x_sat = sat_pos(upd_x, X_MAX);
  assign upd_y_sat = sat_pos(upd_y, Y_MAX);

  // Frame phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_ACTIVE;
    else     state <= state_n;
  end

  // Phase changes on the last pixel of the last active / last blank line.
  always_comb begin
    state_n = state;
    case (state)
      S_ACTIVE: if (line_end && (v_cnt == 10'(V_ACTIVE - 1))) state_n = S_VBLANK;
      S_VBLANK: if (line_end && (v_cnt == 10'(V_TOTAL - 1)))  state_n = S_ACTIVE;
      default:  state_n = S_ACTIVE;
    endcase
  end

  // Ready is a flop tracking the phase register exactly (fed from next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) upd_ready <= 1'b0;
    else     upd_ready <= (state_n == S_VBLANK);
  end

  // Shadow takes accepted moves; live copies at frame start, bypassing the
  // shadow when a move is accepted on that very cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shx <= '0;
      shy <= '0;
      sx  <= '0;
      sy  <= '0;
    end else begin
      if (accept) begin
        shx <= upd_x_sat;
        shy <= upd_y_sat;
      end
      if (frame_go) begin
        sx <= accept ? upd_x_sat : shx;
        sy <= accept ? upd_y_sat : shy;
      end
    end
  end

  assign in_sprite = (h_cnt >= sx) && ({1'b0, h_cnt} < ({1'b0, sx} + SPR_W)) &&
                     (v_cnt >= sy) && ({1'b0, v_cnt} < ({1'b0, sy} + SPR_W));
  assign on_grid   = ((h_cnt & GRID_MASK) < LINE_W) || ((v_cnt & GRID_MASK) < LINE_W);

  // Layer decode for the current counter position.
  always_comb begin
    sel_p0 = SEL_FONDO;
    if (active) begin
      if (in_sprite)    sel_p0 = SEL_SPRIT;
      else if (on_grid) sel_p0 = SEL_LINEAS;
`ifdef VGA_LAYER_TEST_PATTERN_EN
      if (test_en) sel_p0 = (h_cnt[5] ^ v_cnt[5]) ? SEL_PRU : SEL_FONDO;
`endif
    end
  end

  // Stage p1: registered select, active flag, frame marker, first sync delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_p1 <= SEL_FONDO;
      vid_p1 <= 1'b0;
      fs_p1  <= 1'b0;
      hs_p1  <= 1'b1;
      vs_p1  <= 1'b1;
    end else begin
      sel_p1 <= sel_p0;
      vid_p1 <= active;
      fs_p1  <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      hs_p1  <= hs_raw;
      vs_p1  <= vs_raw;
    end
  end

  // Stage p2: syncs trail one more cycle to match the downstream colour register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_p2 <= 1'b1;
      vs_p2 <= 1'b1;
    end else begin
      hs_p2 <= hs_p1;
      vs_p2 <= vs_p1;
    end
  end

  assign selector    = sel_p1;
  assign video_on    = vid_p1;
  assign frame_start = fs_p1;
  assign hsync       = hs_p2;
  assign vsync       = vs_p2;

endmodule

// File: tb/tb_vga_layer_ctrl.sv
// tb_vga_layer_ctrl: directed bench for vga_layer_ctrl. Pixel checks come
// from a table of {group, x, y, select, video_on}; the bench jumps the
// vertical counter inside a region to keep the run short.
module tb_vga_layer_ctrl;

  typedef struct {
    int grp;
    int x;
    int y;
    int sel;
    int vid;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       upd_valid;
  logic [9:0] upd_x;
  logic [9:0] upd_y;
  logic       upd_ready;
  logic [1:0] selector;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
`ifdef VGA_LAYER_TEST_PATTERN_EN
  logic       test_en;
`endif

  int         h_m;
  int         v_m;
  int         cyc;
  int         n_tests;
  int         n_fail;
  logic [9:0] jv;
  vec_t       vt[$];

  vga_layer_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef VGA_LAYER_TEST_PATTERN_EN
    .test_en     (test_en),
`endif
    .upd_valid   (upd_valid),
    .upd_x       (upd_x),
    .upd_y       (upd_y),
    .upd_ready   (upd_ready),
    .selector    (selector),
    .hsync       (hsync),
    .vsync       (vsync),
    .video_on    (video_on),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // One clock: model position follows the DUT counters, sample at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      h_m = 0;
      v_m = 0;
    end else if (h_m == 799) begin
      h_m = 0;
      v_m = (v_m == 524) ? 0 : v_m + 1;
    end else begin
      h_m = h_m + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Move the vertical counter to vv (same frame phase, never at line end).
  task automatic jump_v(input int vv);
    jv = 10'(vv);
    force dut.u_timing.v_cnt = jv;
    v_m = vv;
    tick();
    release dut.u_timing.v_cnt;
  endtask

  task automatic goto(input int x, input int y);
    int g;
    while (h_m == 799) tick();
    if (v_m != y) begin
      if (h_m < x)            jump_v(y);
      else if (v_m != y - 1)  jump_v(y - 1);
    end
    g = 0;
    while (!(h_m == x && v_m == y) && g < 2000) begin
      tick();
      g++;
    end
    if (g >= 2000) chk($sformatf("reach(%0d,%0d) h", x, y), h_m, x);
  endtask

  task automatic next_frame();
    goto(799, 479);
    tick();
    goto(799, 524);
    tick();
  endtask

  task automatic run_group(input int g);
    foreach (vt[i]) begin
      if (vt[i].grp == g) begin
        goto(vt[i].x, vt[i].y);
        tick();
        chk($sformatf("g%0d sel(%0d,%0d)", g, vt[i].x, vt[i].y), int'(selector), vt[i].sel);
        chk($sformatf("g%0d vid(%0d,%0d)", g, vt[i].x, vt[i].y), int'(video_on), vt[i].vid);
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fall1;
    int rise1;
    int fall2;
    int n;
    logic prev;

    // group 0: default sprite at (0,0)
    vt.push_back('{0,  10,  10, 3, 1});
    vt.push_back('{0, 700,  10, 0, 0});
    vt.push_back('{0,  31,  31, 3, 1});
    vt.push_back('{0,  32,  31, 0, 1});
    vt.push_back('{0, 100,  70, 0, 1});
    vt.push_back('{0,  64, 100, 2, 1});
    vt.push_back('{0,  65, 101, 2, 1});
    vt.push_back('{0,  66, 101, 0, 1});
    vt.push_back('{0,   0, 479, 2, 1});
    vt.push_back('{0, 639, 479, 0, 1});
    vt.push_back('{0, 640, 479, 0, 0});
    // group 1: after a move requested outside blank (must be ignored)
    vt.push_back('{1,  10,  10, 3, 1});
    vt.push_back('{1, 200, 150, 0, 1});
    // group 2: sprite at (200,150)
    vt.push_back('{2,  10,  10, 0, 1});
    vt.push_back('{2, 100, 100, 0, 1});
    vt.push_back('{2, 199, 150, 0, 1});
    vt.push_back('{2, 200, 150, 3, 1});
    vt.push_back('{2, 231, 181, 3, 1});
    vt.push_back('{2, 232, 181, 0, 1});
    // group 3: request (639,479) clamped to (608,448)
    vt.push_back('{3,  10,  10, 0, 1});
    vt.push_back('{3, 607, 448, 2, 1});
    vt.push_back('{3, 608, 448, 3, 1});
    vt.push_back('{3, 639, 479, 3, 1});
    // groups 4/5: after mid-frame reset, and one frame later
    vt.push_back('{4,  10,  10, 3, 1});
    vt.push_back('{4, 620, 460, 0, 1});
    vt.push_back('{5,  10,  10, 3, 1});
    vt.push_back('{5, 620, 460, 0, 1});
`ifdef VGA_LAYER_TEST_PATTERN_EN
    // group 6: checkerboard
    vt.push_back('{6,   0,   0, 0, 1});
    vt.push_back('{6,  32,   0, 1, 1});
    vt.push_back('{6, 700,   0, 0, 0});
    vt.push_back('{6,   0,  32, 1, 1});
    vt.push_back('{6,  32,  32, 0, 1});
    test_en = 1'b0;
`endif

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    upd_valid = 1'b0;
    upd_x = '0;
    upd_y = '0;
    h_m = 0;
    v_m = 0;
    cyc = 0;
    jv  = '0;
    repeat (3) tick();
    chk("rst selector", int'(selector), 0);
    chk("rst video_on", int'(video_on), 0);
    chk("rst hsync", int'(hsync), 1);
    chk("rst vsync", int'(vsync), 1);
    chk("rst upd_ready", int'(upd_ready), 0);
    chk("rst frame_start", int'(frame_start), 0);

    rst = 1'b0;
    cyc = 0;
    tick();
    chk("first frame_start", int'(frame_start), 1);
    chk("sel(0,0)", int'(selector), 3);
    chk("vid(0,0)", int'(video_on), 1);
    tick();
    chk("frame_start one cycle", int'(frame_start), 0);

    // hsync edges relative to reset release
    fall1 = -1;
    rise1 = -1;
    fall2 = -1;
    prev  = hsync;
    while (cyc < 1700) begin
      tick();
      if (prev && !hsync) begin
        if (fall1 < 0)      fall1 = cyc;
        else if (fall2 < 0) fall2 = cyc;
      end
      if (!prev && hsync && rise1 < 0) rise1 = cyc;
      prev = hsync;
    end
    chk("hsync first fall", fall1, 658);
    chk("hsync low width", rise1 - fall1, 96);
    chk("hsync period", fall2 - fall1, 800);

    run_group(0);

    // active -> blank handover
    goto(799, 479);
    chk("ready last active", int'(upd_ready), 0);
    tick();
    chk("ready first blank", int'(upd_ready), 1);

    // vsync low window
    goto(400, 488);
    goto(1, 490);
    chk("vsync before low", int'(vsync), 1);
    tick();
    chk("vsync goes low", int'(vsync), 0);
    n = 1;
    tick();
    while (vsync == 1'b0 && n < 3000) begin
      n++;
      tick();
    end
    chk("vsync low width", n, 1600);

    // blank -> active handover
    goto(799, 524);
    chk("ready last blank", int'(upd_ready), 1);
    tick();
    chk("ready frame begin", int'(upd_ready), 0);
    tick();
    chk("frame_start after blank", int'(frame_start), 1);

    // move requested mid-frame: refused
    goto(300, 100);
    upd_valid = 1'b1;
    upd_x = 10'd200;
    upd_y = 10'd150;
    chk("ready at v=100", int'(upd_ready), 0);
    repeat (3) tick();
    upd_valid = 1'b0;
    next_frame();
    run_group(1);

    // move requested in blank: accepted
    goto(799, 479);
    tick();
    goto(300, 500);
    upd_valid = 1'b1;
    upd_x = 10'd200;
    upd_y = 10'd150;
    chk("ready at v=500", int'(upd_ready), 1);
    tick();
    upd_valid = 1'b0;
    goto(799, 524);
    tick();
    run_group(2);

    // move accepted on the blank->active cycle, out of range
    goto(799, 479);
    tick();
    goto(799, 524);
    upd_valid = 1'b1;
    upd_x = 10'd639;
    upd_y = 10'd479;
    chk("ready on handover", int'(upd_ready), 1);
    tick();
    upd_valid = 1'b0;
    run_group(3);

    // reset in the middle of a frame
    next_frame();
    goto(300, 200);
    rst = 1'b1;
    h_m = 0;
    v_m = 0;
    repeat (3) tick();
    chk("midrst selector", int'(selector), 0);
    chk("midrst video_on", int'(video_on), 0);
    chk("midrst hsync", int'(hsync), 1);
    chk("midrst vsync", int'(vsync), 1);
    chk("midrst upd_ready", int'(upd_ready), 0);
    chk("midrst frame_start", int'(frame_start), 0);
    rst = 1'b0;
    cyc = 0;
    tick();
    chk("midrst frame_start after", int'(frame_start), 1);
    chk("midrst sel(0,0)", int'(selector), 3);
    run_group(4);
    next_frame();
    run_group(5);

`ifdef VGA_LAYER_TEST_PATTERN_EN
    goto(799, 479);
    tick();
    goto(799, 524);
    test_en = 1'b1;
    tick();
    run_group(6);
    test_en = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_layer_ctrl.md
VGA_LAYER_CTRL -- requirements
Module: vga_layer_ctrl

Interface
REQ-001 Parameter GRID_STEP, default 64, grid line pitch in pixels (power of 2).
REQ-002 Parameter LINE_T, default 2, grid line thickness in pixels (< GRID_STEP).
REQ-003 Parameter SPRITE_SZ, default 32, sprite square side in pixels.
REQ-004 Port clk input 1: single pixel clock, 25 MHz nominal; all logic on its rising edge.
REQ-005 Port rst input 1: reset, asynchronous, active-high.
REQ-006 Port upd_valid input 1: sprite position update request.
REQ-007 Port upd_x input 10, upd_y input 10: requested sprite top-left coordinate.
REQ-008 Port upd_ready output 1: update accepted when high with upd_valid.
REQ-009 Port selector output 2: colour-mux select (00 background, 01 test white, 10 lines, 11 sprite).
REQ-010 Port hsync output 1 and vsync output 1: active-low syncs.
REQ-011 Port video_on output 1: high in the active 640x480 region.
REQ-012 Port frame_start output 1: one-cycle pulse at pixel (0,0).

Function
REQ-013 Horizontal counter 0..799 (640 active, 16 FP, 96 sync, 48 BP); wraps to 0 and increments the vertical counter.
REQ-014 Vertical counter 0..524 (480 active, 10 FP, 2 sync, 33 BP); wraps 524->0.
REQ-015 hsync low for h in 656..751; vsync low for v in 490..491.
REQ-016 FSM states S_ACTIVE (v 0..479) and S_VBLANK (v 480..524); S_ACTIVE->S_VBLANK when h=799,v=479; S_VBLANK->S_ACTIVE when h=799,v=524.
REQ-017 upd_ready = 1 exactly while state is S_VBLANK, registered; upd_valid ignored otherwise (no buffering).
REQ-018 On upd_valid && upd_ready, upd_x/upd_y load a shadow register; last accepted value wins.
REQ-019 Shadow copies to the live sprite position on the S_VBLANK->S_ACTIVE transition; an update accepted on that same cycle applies to the starting frame.
REQ-020 Shadow load clamps x to 640-SPRITE_SZ and y to 480-SPRITE_SZ.
REQ-021 Selector priority outside active region: 00; inside: sprite (x in [sx,sx+SPRITE_SZ), y in [sy,sy+SPRITE_SZ)) -> 11, else grid line (h mod GRID_STEP < LINE_T or v mod GRID_STEP < LINE_T) -> 10, else 00.
REQ-022 selector and video_on registered: valid 1 cycle after the counter value they describe.
REQ-023 hsync/vsync delayed 2 cycles from counter to align with the colour mux's registered output.
REQ-024 frame_start asserts in the cycle selector describes (0,0).

Reset
REQ-025 While rst high: counters 0, state S_ACTIVE, selector 00, video_on 0, hsync 1, vsync 1, upd_ready 0, frame_start 0, shadow and live positions (0,0), all delay stages cleared.
REQ-026 Reset mid-frame aborts the frame; first frame_start pulses 1 cycle after rst deasserts.

Configuration
REQ-027 Macro VGA_LAYER_TEST_PATTERN_EN defined: input port test_en (1 bit) added; when high, active pixels with (h[5] xor v[5]) = 1 give selector 01 and all other active pixels 00, overriding REQ-021.
REQ-028 Macro undefined: no test_en port; selector never 01.

Structure
REQ-029 Package vga_pkg holds timing constants (active, FP, sync, BP per axis; totals 800/525), selector enum SEL_FONDO/SEL_PRU/SEL_LINEAS/SEL_SPRIT, and FSM state enum.
REQ-030 Sub-module vga_timing holds counters, raw syncs and the active flag; vga_layer_ctrl holds FSM, handshake, position registers, layer decode and alignment delays.

Verification
REQ-031 Release reset, run 2 frames -> hsync period 800 clk, low 96; vsync period 420000 clk, low 1600; frame_start every 420000 clk.
REQ-032 Defaults, sprite at (0,0) -> pixel (100,70) selector 00, (64,100) 10, (10,10) 11, (700,10) 00.
REQ-033 upd_valid with (200,150) during v=100 -> upd_ready 0, sprite unchanged; same request at v=500 -> accepted; next frame (200,150) gives 11, (100,100) gives 00 or 10 only.
REQ-034 Update (639,479) -> clamped to (608,448); pixel (639,479) selector 11.
REQ-035 Assert rst at h=300,v=200 for 3 cycles -> outputs at reset values; frame_start 1 cycle after release; position (0,0).
REQ-036 With VGA_LAYER_TEST_PATTERN_EN, test_en=1 -> pixel (32,0) selector 01, (0,0) 00, (32,32) 00, blanking 00.
